tdm_demux_1x8: RTL and testbench
================================

# tdm_demux_1x8

Time-division demultiplexer, the receive-side counterpart of the team's 8x1 multiplexers. It takes one time-multiplexed stream of eight slots per frame, marked by a frame-sync strobe on slot 0, and routes slot k to parallel output k. The outputs update together once per complete frame. It sits downstream of a mux-based serializer and rebuilds the eight channels a..h, preserving the select ordering s1 (MSB), s2, s3 (LSB).

## Interface
- WIDTH, 1, bits per slot (per channel)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- i  input  WIDTH  slot data
- i_valid  input  1  i carries a slot this cycle
- sync  input  1  frame start; qualified by i_valid; marks slot 0
- a, b, c, d, e, f, g, h  output  WIDTH each  registered channel outputs for slots 0..7
- frame_valid  output  1  one-cycle pulse when a..h update
- sync_err  output  1  one-cycle pulse on framing error
- locked  output  1  high while in LOCKED state
- slot  output  3  index of the next expected slot
- frame_cnt  output  8  count of completed frames; wraps 255 -> 0

## Operation
- States: HUNT and LOCKED. Reset enters HUNT.
- Slot mapping: slot 0 -> a, 1 -> b, 2 -> c, 3 -> d, 4 -> e, 5 -> f, 6 -> g, 7 -> h. This equals the mux select value {s1,s2,s3}.
- Shadow registers sh[0..6] collect slots 0..6. Outputs a..h change only on frame completion.
- Cycles with i_valid=0 change nothing (sync is ignored). Gaps of any length are allowed within a frame.
- HUNT:
  - i_valid & ~sync: sample discarded; stay in HUNT.
  - i_valid & sync: sh[0] <= i; slot <= 1; go to LOCKED.
- LOCKED, slot 0 expected:
  - i_valid & sync: sh[0] <= i; slot <= 1.
  - i_valid & ~sync: missing sync. Pulse sync_err, discard the sample, go to HUNT, slot <= 0.
- LOCKED, slot 1..6 expected:
  - i_valid & ~sync: sh[slot] <= i; slot <= slot+1.
  - i_valid & sync: early sync. Pulse sync_err and discard the partial frame. Treat the sample as a new slot 0: sh[0] <= i, slot <= 1, stay in LOCKED.
- LOCKED, slot 7 expected:
  - i_valid & ~sync: a..g <= sh[0..6]; h <= i; pulse frame_valid; frame_cnt <= frame_cnt+1 (mod 256); slot <= 0.
  - i_valid & sync: early sync, handled as in the slot 1..6 case. No frame is output.
- Discarded partial frames never reach a..h. a..h keep the last complete frame.
- sync_err and frame_valid are never high in the same cycle.
- locked = (state == LOCKED).

## Timing
- Reset values (asynchronous, take effect immediately on rst): a..h = 0, frame_valid = 0, sync_err = 0, locked = 0, slot = 0, frame_cnt = 0, sh[*] = 0, state = HUNT.
- rst asserted mid-frame: partial frame lost, all of the above apply. The first valid sample after rst deasserts is handled in HUNT.
- All outputs are registered.
- Latency: if slot 7 is sampled at edge N, then a..h, frame_valid and frame_cnt take their new values after edge N. frame_valid is high for exactly the cycle following edge N.
- sync_err is high for exactly the cycle following the edge that sampled the error.
- Back-to-back frames with i_valid held high give one frame_valid every 8 cycles. There are no bubbles and no throughput loss.
- Minimum frame: 8 consecutive valid cycles. No maximum.

## Test plan
- Reset, then with WIDTH=1 drive 8 consecutive valid slots 1,0,1,1,0,0,1,0 (sync on the first) -> one cycle after the 8th edge: a..h = 1,0,1,1,0,0,1,0, frame_valid pulses once, frame_cnt = 1, locked = 1.
- Same frame with i_valid low for 3 cycles between slots 3 and 4 -> identical outputs; a..h stay unchanged until slot 7 is sampled.
- After a good frame, assert sync with slot 5 of the next frame -> sync_err pulses, a..h keep the old frame. A full frame starting at that sample updates a..h 8 valid cycles later.
- In LOCKED, drive slot 0 without sync -> sync_err pulses, locked = 0, slot = 0. Further non-sync samples are ignored until sync arrives.
- Assert rst during slot 4 of a frame -> all outputs 0 immediately, locked = 0. A subsequent clean frame outputs correctly with frame_cnt = 1.
- Run 257 back-to-back frames -> frame_valid every 8th cycle; frame_cnt wraps 255 -> 0 -> 1.

Source files
------------

// File: rtl/tdm_demux_1x8.sv
// Time-division demultiplexer: splits a sync-framed stream of eight slots per frame
// into eight registered channel outputs a..h, updated together once per complete frame.
module tdm_demux_1x8 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i,
    input  logic             i_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic             frame_valid,
    output logic             sync_err,
    output logic             locked,
    output logic [2:0]       slot,
    output logic [7:0]       frame_cnt
);

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]       state_r;
    logic [0:0]       state_s;
    logic [2:0]       slot_r;
    logic [2:0]       slot_s;
    logic [WIDTH-1:0] sh_r  [0:6];
    logic [WIDTH-1:0] out_r [0:7];
    logic             frame_valid_r;
    logic             sync_err_r;
    logic [7:0]       frame_cnt_r;

    logic             sh_we_s;
    logic [2:0]       sh_idx_s;
    logic             frame_done_s;
    logic             err_s;

    // Framing decision for the current sample: next state/slot, shadow write, frame or error event.
    always_comb begin
        state_s      = state_r;
        slot_s       = slot_r;
        sh_we_s      = 1'b0;
        sh_idx_s     = 3'd0;
        frame_done_s = 1'b0;
        err_s        = 1'b0;
        if (i_valid) begin
            case (state_r)
                ST_HUNT: begin
                    if (sync) begin
                        state_s = ST_LOCKED;
                        slot_s  = 3'd1;
                        sh_we_s = 1'b1;
                    end else begin
                        state_s = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    if (slot_r == 3'd0) begin
                        if (sync) begin
                            sh_we_s = 1'b1;
                            slot_s  = 3'd1;
                        end else begin
                            err_s   = 1'b1;
                            state_s = ST_HUNT;
                            slot_s  = 3'd0;
                        end
                    end else if (sync) begin
                        // Early sync: the partial frame is abandoned and this sample restarts it.
                        err_s   = 1'b1;
                        sh_we_s = 1'b1;
                        slot_s  = 3'd1;
                    end else if (slot_r == 3'd7) begin
                        frame_done_s = 1'b1;
                        slot_s       = 3'd0;
                    end else begin
                        sh_we_s  = 1'b1;
                        sh_idx_s = slot_r;
                        slot_s   = slot_r + 3'd1;
                    end
                end
                default: begin
                    state_s = ST_HUNT;
                    slot_s  = 3'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Frame alignment state and next-expected slot index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_HUNT;
            slot_r  <= 3'd0;
        end else begin
            state_r <= state_s;
            slot_r  <= slot_s;
        end
    end

    // Shadow registers collecting slots 0..6 of the frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 7; k++) begin
                sh_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 7; k++) begin
                if (sh_we_s && (sh_idx_s == 3'(k))) begin
                    sh_r[k] <= i;
                end else begin
                    sh_r[k] <= sh_r[k];
                end
            end
        end
    end

    // Channel outputs: loaded all at once when slot 7 completes a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                out_r[k] <= '0;
            end
        end else if (frame_done_s) begin
            for (int k = 0; k < 7; k++) begin
                out_r[k] <= sh_r[k];
            end
            out_r[7] <= i;
        end else begin
            for (int k = 0; k < 8; k++) begin
                out_r[k] <= out_r[k];
            end
        end
    end

    // Event pulses and completed-frame counter (wraps modulo 256).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_valid_r <= 1'b0;
            sync_err_r    <= 1'b0;
            frame_cnt_r   <= 8'd0;
        end else begin
            frame_valid_r <= frame_done_s;
            sync_err_r    <= err_s;
            if (frame_done_s) begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    assign a           = out_r[0];
    assign b           = out_r[1];
    assign c           = out_r[2];
    assign d           = out_r[3];
    assign e           = out_r[4];
    assign f           = out_r[5];
    assign g           = out_r[6];
    assign h           = out_r[7];
    assign frame_valid = frame_valid_r;
    assign sync_err    = sync_err_r;
    assign locked      = (state_r == ST_LOCKED);
    assign slot        = slot_r;
    assign frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Bench for tdm_demux_1x8: directed framing scenarios plus randomized traffic,
// every output compared each cycle against a queue-based frame model.
module tb_tdm_demux_1x8;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] i;
    logic             i_valid;
    logic             sync;
    logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
    logic             frame_valid;
    logic             sync_err;
    logic             locked;
    logic [2:0]       slot;
    logic [7:0]       frame_cnt;

    int checks_s   = 0;
    int failures_s = 0;

    // Reference model: a frame is simply the list of samples accepted since the last slot 0.
    bit               m_locked;
    logic [WIDTH-1:0] m_part[$];
    logic [WIDTH-1:0] m_out[8];
    bit               m_fv;
    bit               m_err;
    int               m_cnt;

    tdm_demux_1x8 #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .i(i), .i_valid(i_valid), .sync(sync),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .frame_valid(frame_valid), .sync_err(sync_err), .locked(locked),
        .slot(slot), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_s++;
        if (obs !== exp) begin
            failures_s++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_part.delete();
        for (int k = 0; k < 8; k++) m_out[k] = '0;
        m_fv  = 1'b0;
        m_err = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_step(input bit v, input bit s, input logic [WIDTH-1:0] x);
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_locked = 1'b1;
                    m_part   = {x};
                end
            end else if (m_part.size() == 0) begin
                if (s) begin
                    m_part = {x};
                end else begin
                    m_err    = 1'b1;
                    m_locked = 1'b0;
                end
            end else if (s) begin
                m_err  = 1'b1;
                m_part = {x};
            end else begin
                m_part.push_back(x);
                if (m_part.size() == 8) begin
                    for (int k = 0; k < 8; k++) m_out[k] = m_part[k];
                    m_fv  = 1'b1;
                    m_cnt = (m_cnt + 1) % 256;
                    m_part.delete();
                end
            end
        end
    endtask

    task automatic check_all(input string ctx);
        logic [31:0] exp_ch;
        exp_ch = '0;
        for (int k = 0; k < 8; k++) exp_ch = (exp_ch << WIDTH) | 32'(m_out[k]);
        check_eq({ctx, ".chan"}, {a, b, c, d, e, f, g, h}, exp_ch);
        check_eq({ctx, ".frame_valid"}, 32'(frame_valid), 32'(m_fv));
        check_eq({ctx, ".sync_err"}, 32'(sync_err), 32'(m_err));
        check_eq({ctx, ".locked"}, 32'(locked), 32'(m_locked));
        check_eq({ctx, ".slot"}, 32'(slot), m_locked ? 32'(m_part.size()) : 32'd0);
        check_eq({ctx, ".frame_cnt"}, 32'(frame_cnt), 32'(m_cnt));
    endtask

    // One clock: drive inputs, let the edge happen, update the model, check 1 time unit later.
    task automatic step(input string ctx, input bit v, input bit s, input logic [WIDTH-1:0] x);
        i_valid = v;
        sync    = s;
        i       = x;
        @(posedge clk);
        model_step(v, s, x);
        #1;
        check_all(ctx);
    endtask

    task automatic async_reset(input string ctx);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all(ctx);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_frame(input string ctx, input logic [WIDTH-1:0] v[8]);
        for (int k = 0; k < 8; k++) step(ctx, 1'b1, k == 0, v[k]);
    endtask

    initial begin
        logic [WIDTH-1:0] fr[8];
        logic [WIDTH-1:0] rnd[8];
        int fv_seen;

        rst = 1'b1; i = '0; i_valid = 1'b0; sync = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        fr = '{4'd1, 4'd0, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 4'd0};
        step("idle", 1'b0, 1'b1, 4'd9);
        send_frame("frame1", fr);
        check_eq("frame1.cnt_direct", 32'(frame_cnt), 32'd1);
        step("after1", 1'b0, 1'b0, '0);

        // Same frame with a 3-cycle gap between slots 3 and 4, distinct data.
        fr = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd15};
        for (int k = 0; k < 4; k++) step("gap", 1'b1, k == 0, fr[k]);
        for (int k = 0; k < 3; k++) step("gap.idle", 1'b0, k == 1, 4'd8);
        for (int k = 4; k < 8; k++) step("gap", 1'b1, 1'b0, fr[k]);
        check_eq("gap.h_direct", 32'(h), 32'd15);

        // Early sync on slot 5 restarts the frame from that sample.
        fr = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'h3, 4'h2, 4'h1};
        for (int k = 0; k < 5; k++) step("early", 1'b1, k == 0, fr[k]);
        step("early.sync", 1'b1, 1'b1, 4'h9);
        for (int k = 1; k < 8; k++) step("early.refill", 1'b1, 1'b0, 4'(k));
        // Early sync on slot 7 must not output a frame.
        for (int k = 0; k < 7; k++) step("early7", 1'b1, k == 0, 4'hC);
        step("early7.sync", 1'b1, 1'b1, 4'h5);
        for (int k = 1; k < 8; k++) step("early7.refill", 1'b1, 1'b0, 4'(k + 8));

        // Missing sync on slot 0 drops to HUNT; non-sync samples ignored.
        step("nosync", 1'b1, 1'b0, 4'h6);
        for (int k = 0; k < 5; k++) step("hunt", 1'b1, 1'b0, 4'(k));
        fr = '{4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hC, 4'hE, 4'hF};
        send_frame("relock", fr);

        // Reset in the middle of a frame.
        for (int k = 0; k < 5; k++) step("prerst", 1'b1, k == 0, 4'(k + 3));
        async_reset("midrst");
        step("postrst.hunt", 1'b1, 1'b0, 4'h7);
        fr = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        send_frame("postrst", fr);
        check_eq("postrst.cnt_direct", 32'(frame_cnt), 32'd1);

        // 257 back-to-back frames: exactly one frame_valid per 8 cycles, counter wraps.
        fv_seen = 0;
        for (int n = 0; n < 257; n++) begin
            for (int k = 0; k < 8; k++) rnd[k] = WIDTH'($urandom);
            for (int k = 0; k < 8; k++) begin
                step("b2b", 1'b1, k == 0, rnd[k]);
                if (frame_valid) fv_seen++;
            end
        end
        check_eq("b2b.fv_count", 32'(fv_seen), 32'd257);
        check_eq("b2b.cnt_wrap", 32'(frame_cnt), 32'd2);

        // Random traffic: gaps, mostly-correct syncs, occasional framing errors and resets.
        for (int n = 0; n < 3000; n++) begin
            bit v;
            bit s;
            v = ($urandom_range(0, 3) != 0);
            if (m_locked && m_part.size() == 0) s = ($urandom_range(0, 19) != 0);
            else if (!m_locked) s = ($urandom_range(0, 3) == 0);
            else s = ($urandom_range(0, 29) == 0);
            step("rand", v, s, WIDTH'($urandom));
            if ($urandom_range(0, 499) == 0) async_reset("rand.rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
